// File: rtl/simple_bus_mem_slave.sv
// Memory-backed simple_bus slave: grants the bus, captures one access per start,
// inserts WAIT_STATES wait cycles, then pulses rdy. Define SB_MEM_ERR_EN for the err port.
module simple_bus_mem_slave #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  output logic                  gnt,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdy
`ifdef SB_MEM_ERR_EN
  ,
  output logic                  err
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, ACCESS, DONE} state_t;

  state_t                state, state_next;
  logic [3:0]            wait_cnt;
  logic [1:0]            mode_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  in_range, bad, is_read, is_write;
  logic [IDX_W-1:0]      idx;

  // Widened compare so DEPTH == 2**ADDR_WIDTH does not wrap to zero.
  assign in_range = {1'b0, addr_q} < (ADDR_WIDTH+1)'(DEPTH);
  assign idx      = addr_q[IDX_W-1:0];

`ifdef SB_MEM_ERR_EN
  assign bad = !in_range || (mode_q == 2'b11);
`else
  assign bad = !in_range;
`endif

  assign is_read  = (mode_q == 2'b01) && !bad;
  assign is_write = (mode_q == 2'b10) && !bad;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = GRANT;
      GRANT: begin
        if (start)     state_next = ACCESS;
        else if (!req) state_next = IDLE;
      end
      ACCESS:  if (wait_cnt == 4'(WAIT_STATES)) state_next = DONE;
      DONE:    state_next = req ? GRANT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      rdy      <= 1'b0;
      rdata    <= '0;
      wait_cnt <= '0;
      mode_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
`ifdef SB_MEM_ERR_EN
      err      <= 1'b0;
`endif
      for (int unsigned i = 0; i < unsigned'(DEPTH); i++) mem[i] <= '0;
    end else begin
      state <= state_next;
      // Outputs are registered from the next state so they align with it.
      gnt   <= (state_next != IDLE);
      rdy   <= (state_next == DONE);
      rdata <= '0;
`ifdef SB_MEM_ERR_EN
      err   <= 1'b0;
`endif
      if (state == GRANT && start) begin
        mode_q   <= mode;
        addr_q   <= addr;
        wdata_q  <= wdata;
        wait_cnt <= '0;
      end else if (state == ACCESS) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      // No write can land between capture and DONE, so reading here equals capture-time data.
      if (state == ACCESS && state_next == DONE) begin
        rdata <= is_read ? mem[idx] : '0;
`ifdef SB_MEM_ERR_EN
        err   <= bad;
`endif
      end
      if (state == DONE && is_write) mem[idx] <= wdata_q;
    end
  end

endmodule
